// File: rtl/conv_mdc_tcdm_responder.sv
// Multi-port word-interleaved TCDM responder for the conv_mdc accelerator.
// Round-robin bank arbitration, 1-cycle read latency, conflict counter.
module conv_mdc_tcdm_responder #(
  parameter int MP    = 2,
  parameter int NB    = 4,
  parameter int DEPTH = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [MP-1:0]    tcdm_req_i,
  output logic [MP-1:0]    tcdm_gnt_o,
  input  logic [MP*32-1:0] tcdm_add_i,
  input  logic [MP-1:0]    tcdm_wen_i,
  input  logic [MP*4-1:0]  tcdm_be_i,
  input  logic [MP*32-1:0] tcdm_data_i,
  output logic [MP*32-1:0] tcdm_r_data_o,
  output logic [MP-1:0]    tcdm_r_valid_o,
  output logic [31:0]      conflict_cnt_o
);

  localparam int LNB = $clog2(NB);
  localparam int BW  = (NB > 1) ? LNB : 1;
  localparam int RW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = (MP > 1) ? $clog2(MP) : 1;

  logic [31:0]   mem [NB][DEPTH];
  logic [BW-1:0] bank_sel [MP];
  logic [RW-1:0] row_sel [MP];
  logic [PW-1:0] rr_ptr [NB];
  logic [PW-1:0] bank_port [NB];
  logic [NB-1:0] bank_gnt;
  logic [MP-1:0] gnt;
  logic          any_conf;
  logic          unused_add;

  // Address bits outside the bank/row window are ignored by design.
  assign unused_add = ^tcdm_add_i;

  // Split each port's word address into bank and row.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      bank_sel[p] = '0;
      row_sel[p]  = '0;
      if (NB > 1)
        bank_sel[p] = BW'(tcdm_add_i[p*32+2 +: 30]);
      if (DEPTH > 1)
        row_sel[p] = RW'(tcdm_add_i[p*32+2 +: 30] >> LNB);
    end
  end

  // Per-bank round-robin: first requester at or after rr_ptr wins.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    gnt      = '0;
    bank_gnt = '0;
    sum      = '0;
    idx      = '0;
    for (int b = 0; b < NB; b++) begin
      bank_port[b] = '0;
      for (int i = 0; i < MP; i++) begin
        sum = {1'b0, rr_ptr[b]} + (PW+1)'(i);
        if (sum >= (PW+1)'(MP))
          sum = sum - (PW+1)'(MP);
        idx = sum[PW-1:0];
        if (!bank_gnt[b] && tcdm_req_i[idx] &&
            bank_sel[idx] == BW'(b)) begin
          gnt[idx]     = 1'b1;
          bank_gnt[b]  = 1'b1;
          bank_port[b] = idx;
        end
      end
    end
  end

  assign tcdm_gnt_o = gnt;
  assign any_conf   = |(tcdm_req_i & ~gnt);

  // Advance each bank pointer past the port it just served.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NB; b++) rr_ptr[b] <= '0;
    end else if (clear_i) begin
      for (int b = 0; b < NB; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (bank_gnt[b]) begin
          if (bank_port[b] == PW'(MP-1))
            rr_ptr[b] <= '0;
          else
            rr_ptr[b] <= bank_port[b] + 1'b1;
        end
      end
    end
  end

  // Granted writes update the selected bytes; contents survive reset.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      if (gnt[p] && !tcdm_wen_i[p]) begin
        for (int k = 0; k < 4; k++) begin
          if (tcdm_be_i[p*4+k])
            mem[bank_sel[p]][row_sel[p]][k*8 +: 8] <=
              tcdm_data_i[p*32+k*8 +: 8];
        end
      end
    end
  end

  // One-cycle response: valid per grant, data only for reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcdm_r_valid_o <= '0;
      tcdm_r_data_o  <= '0;
    end else if (clear_i) begin
      tcdm_r_valid_o <= '0;
      tcdm_r_data_o  <= '0;
    end else begin
      tcdm_r_valid_o <= gnt;
      for (int p = 0; p < MP; p++) begin
        if (gnt[p] && tcdm_wen_i[p])
          tcdm_r_data_o[p*32 +: 32] <= mem[bank_sel[p]][row_sel[p]];
        else
          tcdm_r_data_o[p*32 +: 32] <= '0;
      end
    end
  end

  // Saturating count of cycles with any stalled request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      conflict_cnt_o <= '0;
    else if (clear_i)
      conflict_cnt_o <= '0;
    else if (any_conf && conflict_cnt_o != 32'hFFFF_FFFF)
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
  end

endmodule

// File: tb/tb_conv_mdc_tcdm_responder.sv
// Directed bench for conv_mdc_tcdm_responder (MP=2, NB=4, DEPTH=256).
// Expected values are hand-computed per scenario.
module tb_conv_mdc_tcdm_responder;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        clear;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [63:0] add;
  logic [1:0]  wen;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic [1:0]  rvalid;
  logic [31:0] cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  conv_mdc_tcdm_responder #(.MP(2), .NB(4), .DEPTH(256)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_r_data_o  (rdata),
    .tcdm_r_valid_o (rvalid),
    .conflict_cnt_o (cnt)
  );

  task automatic drive(input int p, input logic r, input logic [31:0] a,
                       input logic w, input logic [3:0] b,
                       input logic [31:0] d);
    req[p]          = r;
    add[p*32 +: 32] = a;
    wen[p]          = w;
    be[p*4 +: 4]    = b;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic idle();
    req = '0; add = '0; wen = '0; be = '0; wdata = '0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear = 1'b0; idle();
    #12;
    vecs++;
    if (rvalid !== 2'b00) begin
      errs++; $display("FAIL reset_rvalid got %b want 00", rvalid);
    end
    vecs++;
    if (rdata !== 64'd0) begin
      errs++; $display("FAIL reset_rdata got %h want 0", rdata);
    end
    vecs++;
    if (cnt !== 32'd0) begin
      errs++; $display("FAIL reset_cnt got %0d want 0", cnt);
    end
    @(negedge clk); rst_ni = 1'b1;
    edge1();
  endtask

  task automatic test_write_read();
    drive(0, 1, 32'h10, 0, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    vecs++;
    if (gnt !== 2'b01) begin
      errs++; $display("FAIL wr_gnt got %b want 01", gnt);
    end
    edge1();
    drive(0, 1, 32'h10, 1, 4'h0, 32'h0);
    vecs++;
    if (rvalid !== 2'b01 || rdata[31:0] !== 32'd0) begin
      errs++;
      $display("FAIL wr_resp got v=%b d=%h want v=01 d=0",
               rvalid, rdata[31:0]);
    end
    @(negedge clk);
    vecs++;
    if (gnt !== 2'b01) begin
      errs++; $display("FAIL rd_gnt got %b want 01", gnt);
    end
    edge1();
    idle();
    vecs++;
    if (rvalid !== 2'b01 || rdata[31:0] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL rd_resp got v=%b d=%h want v=01 d=deadbeef",
               rvalid, rdata[31:0]);
    end
    edge1();
    vecs++;
    if (rvalid !== 2'b00 || rdata !== 64'd0) begin
      errs++;
      $display("FAIL idle_resp got v=%b d=%h want 0", rvalid, rdata);
    end
  endtask

  task automatic test_byte_enable();
    drive(0, 1, 32'h20, 0, 4'hF, 32'h11223344);
    edge1();
    drive(0, 1, 32'h20, 0, 4'b0101, 32'hAABBCCDD);
    edge1();
    drive(0, 1, 32'h20, 1, 4'h0, 32'h0);
    edge1();
    idle();
    vecs++;
    if (rvalid !== 2'b01 || rdata[31:0] !== 32'h11BB33DD) begin
      errs++;
      $display("FAIL be_read got v=%b d=%h want v=01 d=11bb33dd",
               rvalid, rdata[31:0]);
    end
    edge1();
  endtask

  task automatic test_conflict();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10;
    exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    drive(0, 1, 32'h00, 0, 4'hF, 32'hCAFE0000);
    edge1();
    idle(); clear = 1'b1;
    edge1();
    clear = 1'b0;
    vecs++;
    if (cnt !== 32'd0) begin
      errs++; $display("FAIL clr_cnt got %0d want 0", cnt);
    end
    drive(0, 1, 32'h00, 1, 4'h0, 32'h0);
    drive(1, 1, 32'h10, 1, 4'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vecs++;
      if (gnt !== exp_g[c]) begin
        errs++; $display("FAIL conf_gnt%0d got %b want %b", c, gnt, exp_g[c]);
      end
      edge1();
      vecs++;
      if (rvalid !== exp_g[c] ||
          rdata !== (exp_g[c][0] ? {32'h0, 32'hCAFE0000}
                                 : {32'hDEADBEEF, 32'h0})) begin
        errs++;
        $display("FAIL conf_resp%0d got v=%b d=%h", c, rvalid, rdata);
      end
    end
    idle();
    vecs++;
    if (cnt !== 32'd4) begin
      errs++; $display("FAIL conf_cnt got %0d want 4", cnt);
    end
    edge1();
  endtask

  task automatic test_wrap();
    drive(0, 1, 32'h04, 0, 4'hF, 32'h5A5A5A5A);
    edge1();
    idle();
    drive(1, 1, 32'h1004, 1, 4'h0, 32'h0);
    edge1();
    idle();
    vecs++;
    if (rvalid !== 2'b10 || rdata[63:32] !== 32'h5A5A5A5A) begin
      errs++;
      $display("FAIL wrap got v=%b d=%h want v=10 d=5a5a5a5a",
               rvalid, rdata[63:32]);
    end
    edge1();
  endtask

  task automatic test_parallel();
    drive(0, 1, 32'h00, 1, 4'h0, 32'h0);
    drive(1, 1, 32'h04, 1, 4'h0, 32'h0);
    @(negedge clk);
    vecs++;
    if (gnt !== 2'b11) begin
      errs++; $display("FAIL par_gnt got %b want 11", gnt);
    end
    edge1();
    idle();
    vecs++;
    if (rvalid !== 2'b11 || rdata !== {32'h5A5A5A5A, 32'hCAFE0000}) begin
      errs++;
      $display("FAIL par_resp got v=%b d=%h", rvalid, rdata);
    end
    vecs++;
    if (cnt !== 32'd4) begin
      errs++; $display("FAIL par_cnt got %0d want 4", cnt);
    end
    edge1();
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 32'h10, 1, 4'h0, 32'h0);
    @(negedge clk);
    rst_ni = 1'b0;
    edge1();
    vecs++;
    if (rvalid !== 2'b00 || rdata !== 64'd0 || cnt !== 32'd0) begin
      errs++;
      $display("FAIL rst_mid got v=%b d=%h c=%0d want 0",
               rvalid, rdata, cnt);
    end
    idle();
    @(negedge clk); rst_ni = 1'b1;
    edge1();
  endtask

  task automatic test_clear_mid();
    drive(0, 1, 32'h00, 1, 4'h0, 32'h0);
    drive(1, 1, 32'h10, 1, 4'h0, 32'h0);
    edge1();
    vecs++;
    if (cnt !== 32'd1) begin
      errs++; $display("FAIL pre_clr_cnt got %0d want 1", cnt);
    end
    idle();
    drive(0, 1, 32'h10, 1, 4'h0, 32'h0);
    drive(1, 1, 32'h44, 0, 4'hF, 32'h0BADF00D);
    clear = 1'b1;
    @(negedge clk);
    vecs++;
    if (gnt !== 2'b11) begin
      errs++; $display("FAIL clr_gnt got %b want 11", gnt);
    end
    edge1();
    clear = 1'b0;
    idle();
    vecs++;
    if (rvalid !== 2'b00 || rdata !== 64'd0 || cnt !== 32'd0) begin
      errs++;
      $display("FAIL clr_mid got v=%b d=%h c=%0d want 0",
               rvalid, rdata, cnt);
    end
    drive(0, 1, 32'h00, 1, 4'h0, 32'h0);
    drive(1, 1, 32'h10, 1, 4'h0, 32'h0);
    @(negedge clk);
    vecs++;
    if (gnt !== 2'b01) begin
      errs++; $display("FAIL clr_ptr got %b want 01", gnt);
    end
    edge1();
    idle();
    drive(1, 1, 32'h44, 1, 4'h0, 32'h0);
    edge1();
    idle();
    vecs++;
    if (rvalid !== 2'b10 || rdata[63:32] !== 32'h0BADF00D) begin
      errs++;
      $display("FAIL clr_write got v=%b d=%h want v=10 d=0badf00d",
               rvalid, rdata[63:32]);
    end
    edge1();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_conflict();
    test_wrap();
    test_parallel();
    test_reset_mid();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/conv_mdc_tcdm_responder.md
Name: conv_mdc_tcdm_responder

Overview:
- Multi-port TCDM slave that answers the TCDM master ports of the conv_mdc accelerator, i.e. the memory-side end of the accelerator's TCDM protocol.
- Maps MP request ports onto NB word-interleaved single-port banks.
- Arbitrates bank conflicts round-robin and returns read data with fixed 1-cycle latency.
- Used as the shared-memory model in cluster-less integration and in the accelerator testbench; also counts conflict cycles for bandwidth characterisation.

Parameters:
- MP, 2, number of TCDM slave ports (1..8).
- NB, 4, number of banks, power of two (1..16).
- DEPTH, 256, 32-bit words per bank, power of two.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- clear_i  input  1  synchronous clear of arbiter pointers, response pipeline and counter
- tcdm_req_i  input  MP  request valid per port
- tcdm_gnt_o  output  MP  grant per port, combinational from same-cycle requests
- tcdm_add_i  input  MP x 32  byte address per port
- tcdm_wen_i  input  MP  1 = read, 0 = write
- tcdm_be_i  input  MP x 4  byte enables for writes
- tcdm_data_i  input  MP x 32  write data
- tcdm_r_data_o  output  MP x 32  read data
- tcdm_r_valid_o  output  MP  response valid, one cycle after grant
- conflict_cnt_o  output  32  saturating count of cycles with at least one ungranted request

Behaviour:
- Address decode:
  - word = add[31:2]; bank = word[log2(NB)-1:0]; row = word[log2(NB)+log2(DEPTH)-1:log2(NB)].
  - Higher bits are ignored, so accesses wrap modulo NB*DEPTH words.
  - add[1:0] is ignored.
- Arbitration per bank:
  - Among ports requesting the bank, grant the first at or after rr_ptr[bank], searching upward modulo MP.
  - Exactly one grant per bank per cycle.
  - rr_ptr[bank] <= granted port + 1 (mod MP) on each grant; unchanged if the bank is not granted.
  - Distinct banks are served in parallel.
  - gnt_o[p] = 0 whenever req_i[p] = 0.
- Write (granted, wen=0): at the clock edge, write the bytes of mem[bank][row] selected by be; bytes with be=0 are kept. be=0000 is a legal no-op write.
- Read (granted, wen=1): r_data_o[p] = mem[bank][row] as of the grant edge. Same-cycle writes to other banks are not visible, and a same-bank same-cycle write cannot occur.
- Response:
  - r_valid_o[p] is registered, high exactly one cycle after each grant to p, for reads and writes.
  - r_data_o[p] = 0 in write-response cycles and in idle cycles.
  - Back-to-back grants give back-to-back r_valid.
- Ungranted master: must hold req/add/wen/be/data. The responder keeps no state for it except through rr_ptr.
- Conflict counter: increments by 1 in any cycle where any req_i[p] & ~gnt_o[p]; saturates at 0xFFFFFFFF.
- Reset (rst_ni=0, async):
  - r_valid_o = 0, r_data_o = 0, conflict_cnt_o = 0, all rr_ptr = 0.
  - Memory contents are not reset.
  - A grant in flight when reset asserts produces no response.
- clear_i = 1:
  - Next edge has the same effect on r_valid, r_data, rr_ptr and counter as reset.
  - Requests in that cycle are still granted and still update memory, but produce no r_valid.
- No backpressure on responses: the master must accept r_valid whenever it arrives.

Test Plan:
- MP=2, NB=4, DEPTH=256. Port0 writes 0xDEADBEEF to 0x0000_0010 (be=1111). Next cycle port0 reads it -> gnt same cycle, r_valid one cycle later, r_data=0xDEADBEEF.
- Byte enables: write 0x11223344 to 0x20, then 0xAABBCCDD with be=0101, then read -> 0x11BB33DD.
- Conflict: both ports read bank 0 (0x00 and 0x10) every cycle for 4 cycles -> grants alternate port0, port1, port0, port1; conflict_cnt_o=4.
- Parallel: port0 reads 0x00 (bank0), port1 reads 0x04 (bank1) in the same cycle -> both granted, both r_valid next cycle, conflict_cnt_o unchanged.
- Wrap: write 0x5A5A5A5A to 0x0000_0004, read 0x0000_1004 (NB*DEPTH*4 = 0x1000 offset) -> r_data=0x5A5A5A5A.
- Reset/clear mid-operation: assert rst_ni=0 the cycle after a granted read -> r_valid stays 0 and counter=0. Repeat with clear_i -> same outputs, while a write granted in the clear cycle is later readable.
